// File: rtl/unbalance_monitor_pkg.sv
// rtl/unbalance_monitor_pkg.sv - shared constants, state encoding and width helper for the unbalance monitor
package unbalance_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV_NEG,
    ST_DIV_ZERO,
    ST_CHECK
  } state_t;

  localparam int PCT_SCALE    = 100;
  localparam int PCT_MAX_DFLT = 255;

  // 100 < 2^7, so 100*amp needs seven extra bits over the amplitude width
  function automatic int qw_of(input int m);
    return m + 7;
  endfunction

endpackage

// File: rtl/unbalance_monitor_seq_divider.sv
// rtl/unbalance_monitor_seq_divider.sv - restoring divider, one quotient bit per clock
module seq_divider #(
  parameter int NW = 21,
  parameter int DW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [NW-1:0] quotient
);

  localparam int CW = $clog2(NW + 1);

  logic [DW:0]   rem;
  logic [NW-1:0] quo;
  logic [DW-1:0] dvs;
  logic [CW-1:0] cnt;
  logic          active;

  logic [DW:0]   rem_sh;
  logic [DW:0]   rem_diff;
  logic          fits;

  // dividend bits shift out of quo into the remainder as quotient bits shift in
  always_comb begin
    rem_sh   = {rem[DW-1:0], quo[NW-1]};
    fits     = (rem_sh >= {1'b0, dvs});
    rem_diff = rem_sh - {1'b0, dvs};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !active) begin
        rem    <= '0;
        quo    <= dividend;
        dvs    <= divisor;
        cnt    <= CW'(NW);
        active <= 1'b1;
      end else if (active) begin
        rem <= fits ? rem_diff : rem_sh;
        quo <= {quo[NW-2:0], fits};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/unbalance_monitor.sv
// rtl/unbalance_monitor.sv - voltage unbalance factors with debounced hysteretic alarm
module unbalance_monitor
  import unbalance_monitor_pkg::*;
#(
  parameter int M       = 14,
  parameter int PCT_MAX = PCT_MAX_DFLT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_en,
  input  logic [M-1:0] Vpos_amp,
  input  logic [M-1:0] Vneg_amp,
  input  logic [M-1:0] Vzero_amp,
  input  logic [7:0]   thr_pct,
  input  logic [7:0]   hyst_pct,
  input  logic [7:0]   hold_cnt,
  output logic [7:0]   vuf_pct,
  output logic [7:0]   zuf_pct,
  output logic         vuf_valid,
  output logic         alarm,
  output logic         busy,
  output logic         overrun
);

  localparam int QW = qw_of(M);

  state_t        state, state_nxt;
  logic [M-1:0]  pos_amp;
  logic [M-1:0]  zero_amp;
  logic [QW-1:0] q_neg;
  logic [7:0]    run_cnt;

  logic          div_start;
  logic [QW-1:0] div_dividend;
  logic [M-1:0]  div_divisor;
  logic          div_done;
  logic [QW-1:0] div_quo;

  logic [7:0]    vuf_new, zuf_new;
  logic [7:0]    h_eff, clr_lvl, run_inc;
  logic          hit;

  function automatic logic [7:0] sat_pct(input logic [QW-1:0] q);
    return (q > QW'(PCT_MAX)) ? 8'(PCT_MAX) : q[7:0];
  endfunction

  seq_divider #(.NW(QW), .DW(M)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // the neg division starts straight from the ports; the zero division from the latched copies
  always_comb begin
    state_nxt    = state;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    case (state)
      ST_IDLE: begin
        if (sample_en) begin
          state_nxt    = ST_DIV_NEG;
          div_start    = 1'b1;
          div_dividend = QW'(Vneg_amp) * QW'(PCT_SCALE);
          div_divisor  = Vpos_amp;
        end
      end
      ST_DIV_NEG: begin
        if (div_done) begin
          state_nxt    = ST_DIV_ZERO;
          div_start    = 1'b1;
          div_dividend = QW'(zero_amp) * QW'(PCT_SCALE);
          div_divisor  = pos_amp;
        end
      end
      ST_DIV_ZERO: begin
        if (div_done) state_nxt = ST_CHECK;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    vuf_new = (pos_amp == '0) ? 8'(PCT_MAX) : sat_pct(q_neg);
    zuf_new = (pos_amp == '0) ? 8'(PCT_MAX) : sat_pct(div_quo);
    h_eff   = (hold_cnt == 8'd0) ? 8'd1 : hold_cnt;
    clr_lvl = (thr_pct > hyst_pct) ? (thr_pct - hyst_pct) : 8'd0;
    hit     = alarm ? (vuf_new < clr_lvl) : (vuf_new >= thr_pct);
    run_inc = (run_cnt == 8'hFF) ? 8'hFF : (run_cnt + 8'd1);
  end

  // results, alarm and the vuf_valid pulse all land on the edge that enters CHECK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_amp   <= '0;
      zero_amp  <= '0;
      q_neg     <= '0;
      run_cnt   <= '0;
      vuf_pct   <= '0;
      zuf_pct   <= '0;
      vuf_valid <= 1'b0;
      alarm     <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      vuf_valid <= 1'b0;
      if (state == ST_IDLE && sample_en) begin
        pos_amp  <= Vpos_amp;
        zero_amp <= Vzero_amp;
        busy     <= 1'b1;
      end
      if (sample_en && busy) overrun <= 1'b1;
      if (state == ST_DIV_NEG && div_done) q_neg <= div_quo;
      if (state == ST_DIV_ZERO && div_done) begin
        vuf_pct   <= vuf_new;
        zuf_pct   <= zuf_new;
        vuf_valid <= 1'b1;
        busy      <= 1'b0;
        if (!hit) begin
          run_cnt <= 8'd0;
        end else if (run_inc >= h_eff) begin
          alarm   <= ~alarm;
          run_cnt <= 8'd0;
        end else begin
          run_cnt <= run_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_unbalance_monitor.sv
// tb/tb_unbalance_monitor.sv - scoreboard bench for unbalance_monitor
module tb_unbalance_monitor;

  localparam int M = 14;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sample_en = 1'b0;
  logic [M-1:0] vpos = '0, vneg = '0, vzero = '0;
  logic [7:0]   thr = 8'd200, hyst = 8'd0, hold = 8'd200;
  logic [7:0]   vuf_pct, zuf_pct;
  logic         vuf_valid, alarm, busy, overrun;

  typedef struct {
    logic [7:0] vuf;
    logic [7:0] zuf;
    logic       al;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   pcyc = 0;

  unbalance_monitor #(.M(M), .PCT_MAX(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .Vpos_amp  (vpos),
    .Vneg_amp  (vneg),
    .Vzero_amp (vzero),
    .thr_pct   (thr),
    .hyst_pct  (hyst),
    .hold_cnt  (hold),
    .vuf_pct   (vuf_pct),
    .zuf_pct   (zuf_pct),
    .vuf_valid (vuf_valid),
    .alarm     (alarm),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pcyc <= pcyc + 1;

  function automatic int exp_pct(input int vp, input int v);
    int q;
    if (vp == 0) return 255;
    q = (100 * v) / vp;
    return (q > 255) ? 255 : q;
  endfunction

  always @(negedge clk) begin
    if (!rst && vuf_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: vuf_valid with nothing outstanding at cycle %0d", pcyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks += 4;
        if (vuf_pct !== e.vuf) begin
          failures++;
          $display("FAIL vuf_pct: got %0d expected %0d", vuf_pct, e.vuf);
        end
        if (zuf_pct !== e.zuf) begin
          failures++;
          $display("FAIL zuf_pct: got %0d expected %0d", zuf_pct, e.zuf);
        end
        if (alarm !== e.al) begin
          failures++;
          $display("FAIL alarm: got %0b expected %0b", alarm, e.al);
        end
        if (pcyc != e.due) begin
          failures++;
          $display("FAIL latency: valid at cycle %0d expected %0d", pcyc, e.due);
        end
      end
    end
  end

  task automatic do_sample(input int vp, input int vn, input int vz, input logic al);
    exp_t e;
    @(negedge clk);
    vpos      = vp[M-1:0];
    vneg      = vn[M-1:0];
    vzero     = vz[M-1:0];
    sample_en = 1'b1;
    e.vuf = 8'(exp_pct(vp, vn));
    e.zuf = 8'(exp_pct(vp, vz));
    e.al  = al;
    e.due = pcyc + 45;
    sb.push_back(e);
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL result_timeout: %0d results outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({vuf_pct, zuf_pct, vuf_valid, alarm, busy, overrun} !== 20'h0) begin
      failures++;
      $display("FAIL reset_state: got %h expected 0", {vuf_pct, zuf_pct, vuf_valid, alarm, busy, overrun});
    end
  endtask

  task automatic test_saturation();
    do_sample(100, 300, 0, 1'b0);
    wait_idle();
    do_sample(0, 77, 9999, 1'b0);
    wait_idle();
  endtask

  task automatic test_basic();
    int bad = 0;
    do_sample(1000, 50, 20, 1'b0);
    for (int i = 0; i < 44; i++) begin
      if (busy !== 1'b1 || vuf_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_window: %0d bad cycles expected 0", bad);
    end
    wait_idle();
  endtask

  task automatic test_alarm();
    int   vn_tab[9] = '{4, 4, 4, 2, 2, 2, 1, 1, 1};
    logic al_tab[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    thr  = 8'd3;
    hyst = 8'd1;
    hold = 8'd3;
    for (int i = 0; i < 9; i++) begin
      do_sample(100, vn_tab[i], i, al_tab[i]);
      wait_idle();
    end
  endtask

  task automatic test_restart();
    int vn_tab[5] = '{4, 4, 2, 4, 4};
    for (int i = 0; i < 5; i++) begin
      do_sample(100, vn_tab[i], 0, 1'b0);
      wait_idle();
    end
    thr  = 8'd200;
    hyst = 8'd0;
    hold = 8'd200;
  endtask

  task automatic test_overrun();
    do_sample(1000, 50, 20, 1'b0);
    repeat (9) @(negedge clk);
    vpos      = 14'd3000;
    vneg      = 14'd3000;
    vzero     = 14'd3000;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got %0b expected 1", overrun);
    end
    wait_idle();
  endtask

  task automatic test_abort();
    int nvalid = 0;
    @(negedge clk);
    vpos      = 14'd1000;
    vneg      = 14'd500;
    vzero     = 14'd200;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({vuf_pct, zuf_pct, vuf_valid, alarm, busy, overrun} !== 20'h0) begin
      failures++;
      $display("FAIL abort_clear: got %h expected 0", {vuf_pct, zuf_pct, vuf_valid, alarm, busy, overrun});
    end
    repeat (60) begin
      @(negedge clk);
      if (vuf_valid) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      failures++;
      $display("FAIL abort_no_valid: got %0d pulses expected 0", nvalid);
    end
    do_sample(1000, 50, 20, 1'b0);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int nvalid = 0;
    do_sample(2000, 300, 100, 1'b0);
    while (vuf_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (vuf_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_valid_timeout: got %0b expected 1", vuf_valid);
    end
    vpos      = 14'd100;
    vneg      = 14'd10;
    vzero     = 14'd10;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (vuf_valid) nvalid++;
    end
    checks += 3;
    if (nvalid != 0) begin
      failures++;
      $display("FAIL b2b_ignored: got %0d pulses expected 0", nvalid);
    end
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy: got %0b expected 0", busy);
    end
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_overrun: got %0b expected 0", overrun);
    end
    wait_idle();
  endtask

  task automatic test_random();
    int vp, vn, vz;
    for (int i = 0; i < 6; i++) begin
      vp = $urandom_range(16383, 1);
      vn = $urandom_range(vp, 0);
      vz = $urandom_range(vp, 0);
      do_sample(vp, vn, vz, 1'b0);
      wait_idle();
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_basic();
    test_alarm();
    test_restart();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unbalance_monitor.md
UNBALANCE_MONITOR -- requirements
Module: unbalance_monitor

Interface
REQ-001 SHALL have parameter M, default 14, giving the width of the amplitude inputs.
REQ-002 SHALL have parameter PCT_MAX, default 255, the saturation value of the percentage outputs.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 sample_en  input  1  one-cycle strobe: amplitude inputs valid this cycle.
REQ-006 Vpos_amp  input  M  unsigned positive-sequence amplitude.
REQ-007 Vneg_amp  input  M  unsigned negative-sequence amplitude.
REQ-008 Vzero_amp  input  M  unsigned zero-sequence amplitude.
REQ-009 thr_pct  input  8  alarm set threshold, in percent.
REQ-010 hyst_pct  input  8  alarm hysteresis, in percent.
REQ-011 hold_cnt  input  8  consecutive results required to set or clear the alarm.
REQ-012 vuf_pct  output  8  negative/positive unbalance = floor(100*Vneg_amp/Vpos_amp), saturated to PCT_MAX.
REQ-013 zuf_pct  output  8  zero/positive unbalance = floor(100*Vzero_amp/Vpos_amp), saturated to PCT_MAX.
REQ-014 vuf_valid  output  1  one-cycle pulse when vuf_pct and zuf_pct update.
REQ-015 alarm  output  1  debounced unbalance alarm.
REQ-016 busy  output  1  high while a computation is in progress.
REQ-017 overrun  output  1  sticky flag: a sample_en arrived while busy.

Function
REQ-018 The FSM SHALL have four states: IDLE, DIV_NEG, DIV_ZERO, CHECK.
REQ-019 In IDLE, sample_en SHALL latch all three amplitudes and enter DIV_NEG; busy SHALL be high from the next cycle until vuf_valid.
REQ-020 DIV_NEG SHALL compute 100*Vneg_amp/Vpos_amp with a restoring divider at one quotient bit per cycle, over QW = M+7 cycles, then enter DIV_ZERO.
REQ-021 DIV_ZERO SHALL compute 100*Vzero_amp/Vpos_amp the same way over QW cycles, then enter CHECK.
REQ-022 CHECK SHALL register the saturated quotients, update the alarm logic, pulse vuf_valid, and return to IDLE.
REQ-023 Latency SHALL be fixed: a sample_en accepted at edge n gives vuf_valid at edge n+2*QW+2 (n+44 for M=14).
REQ-024 A quotient greater than PCT_MAX SHALL output PCT_MAX.
REQ-025 Vpos_amp=0 SHALL force both outputs to PCT_MAX, with unchanged latency.
REQ-026 sample_en while busy SHALL be ignored and SHALL set overrun; overrun SHALL clear only on rst.
REQ-027 sample_en in the same cycle as vuf_valid SHALL be ignored, because the FSM is not yet in IDLE.
REQ-028 Effective hold H SHALL be max(hold_cnt,1).
REQ-029 Clear level L SHALL be thr_pct-hyst_pct, saturating at 0.
REQ-030 With alarm=0: each result with vuf_pct>=thr_pct SHALL increment a run counter, and any other result SHALL zero it; at count H, alarm SHALL set and the counter SHALL zero.
REQ-031 With alarm=1: each result with vuf_pct<L SHALL increment the run counter, and any other result SHALL zero it; at count H, alarm SHALL clear and the counter SHALL zero.
REQ-032 alarm SHALL change only in the cycle vuf_valid pulses.
REQ-033 The run counter SHALL saturate at 255.
REQ-034 thr_pct, hyst_pct and hold_cnt SHALL be sampled in CHECK.

Reset
REQ-035 rst SHALL asynchronously force state IDLE and clear vuf_pct, zuf_pct, vuf_valid, alarm, busy, overrun, the run counter and the divider registers.
REQ-036 rst during DIV_NEG or DIV_ZERO SHALL abort the computation; no vuf_valid SHALL follow for the aborted sample.
REQ-037 After rst deasserts, the first sample_en SHALL be accepted normally.

Structure
REQ-038 A shared package SHALL hold the state encodings, QW as a function of M, PCT_MAX, and the constant 100.
REQ-039 The restoring divider SHALL be one sub-module, seq_divider (start/done handshake, parameterised width), reused for both divisions.

Verification
REQ-040 M=14, Vpos=1000, Vneg=50, Vzero=20, one sample_en -> vuf_valid exactly 44 cycles later with vuf_pct=5, zuf_pct=2; busy high for the intervening cycles.
REQ-041 Vpos=100, Vneg=300, Vzero=0 -> vuf_pct=255, zuf_pct=0; Vpos=0, any Vneg and Vzero -> both outputs 255 at the same latency.
REQ-042 thr=3, hyst=1, hold=3; results vuf 4,4,4 -> alarm rises at the third vuf_valid; then 2,2,2 -> alarm stays high; then 1,1,1 -> alarm falls at the third vuf_valid.
REQ-043 Results 4,4,2,4,4 with thr=3, hold=3 -> alarm stays low, because the run counter restarts on the 2.
REQ-044 sample_en pulsed 10 cycles after an accepted one -> ignored, overrun=1, first result unaffected; rst pulsed at cycle 20 of a computation -> all outputs 0 and no vuf_valid follows.
